cp_removal: RTL and testbench
=============================

// Module: cp_removal
// PURPOSE
//   Receive-side PUSCH cyclic-prefix removal, the inverse of the TX CP-insertion stage.
//   Accepts a contiguous time-domain sample stream, one subframe = 14 symbols.
//   Strips NCP1 (symbols 0,7) or NCP2 (all other symbols) leading samples per symbol.
//   Forwards exactly IFFT_SIZE samples per symbol, with framing markers, to the RX FFT.
//   Streaming only, no symbol memory. Output stage is registered.
// PARAMETERS
//   WIDTH      26    bits per I/Q component
//   IFFT_SIZE  2048  FFT window length, samples per symbol body
//   N_SYMB     14    symbols per subframe
//   NCP1       160   CP length, symbols 0 and N_SYMB/2
//   NCP2       144   CP length, all other symbols
//   WIN_OFFSET 8     FFT window advance into the CP; used only with CP_REMOVE_WIN_OFFSET_EN; must be < NCP2
// PORTS
//   clk        in   1      clock
//   rst        in   1      reset, asynchronous, active-low
//   valid_in   in   1      input sample qualifier
//   sof_in     in   1      first sample of subframe (first CP sample of symbol 0); used only when valid_in=1
//   data_in_r  in   WIDTH  input real, signed
//   data_in_i  in   WIDTH  input imag, signed
//   valid_out  out  1      output sample qualifier
//   data_out_r out  WIDTH  output real, signed
//   data_out_i out  WIDTH  output imag, signed
//   sym_idx    out  4      symbol index 0..N_SYMB-1 of the current output sample
//   sos_out    out  1      first body sample of a symbol
//   eos_out    out  1      last (IFFT_SIZE-th) body sample of a symbol
//   sf_done    out  1      1-cycle pulse coincident with eos_out of symbol N_SYMB-1
//   err_sync   out  1      1-cycle pulse: sof_in seen while not at a symbol-0 boundary
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; sym/sample counters 0.
//   Reset mid-operation: same state as reset; the partial symbol is abandoned.
//   Latency: 1 clk, valid_in sample -> valid_out/data_out.
//   Handshake: no backpressure. Counters advance only on valid_in=1.
//   When valid_in=0: counters hold, valid_out=0, data_out holds.
//   When valid_out=0: sos_out, eos_out and sf_done are 0.
//   FSM:
//     IDLE:  discard samples until valid_in & sof_in; that sample is CP sample 0 of symbol 0 -> CP.
//     CP:    discard cp_len(sym) samples; cp_len = NCP1 when sym==0 or sym==N_SYMB/2, else NCP2.
//            After the last CP sample -> BODY.
//     BODY:  forward IFFT_SIZE samples. valid_out=1; sos_out on the 1st, eos_out on the last.
//            After the last sample: sym==N_SYMB-1 -> sf_done, sym=0; else sym+1. Then -> CP (or TAIL with macro).
//   Back-to-back subframes are contiguous; no new sof_in is needed.
//   sof_in on the 1st CP sample of symbol 0: accepted silently.
//   sof_in anywhere else (outside IDLE): pulse err_sync; resync so this sample is CP sample 0 of symbol 0.
//     No eos_out is issued for the truncated symbol. Downstream flushes on the next sos_out with sym_idx==0.
//   Sample counter is 12 bits, compare-and-clear. No wrap beyond cp_len-1 or IFFT_SIZE-1.
//   Data passes unmodified; no arithmetic, no width change.
// CONFIGURATION
//   CP_REMOVE_WIN_OFFSET_EN defined:
//     CP discards cp_len-WIN_OFFSET samples, BODY forwards IFFT_SIZE samples.
//     New state TAIL then discards WIN_OFFSET trailing samples before the next CP.
//     Symbol period is unchanged. Downstream applies the phase correction.
//   CP_REMOVE_WIN_OFFSET_EN undefined: WIN_OFFSET ignored; no TAIL state; window starts exactly after the CP.
// STRUCTURE
//   Package cp_pkg:
//     IFFT_SIZE, NCP1, NCP2, N_SYMB constants.
//     typedef enum {IDLE, CP, BODY, TAIL} cp_state_t.
//     function cp_len(sym).
//   Sub-module cp_sym_timer: FSM + sample/symbol counters; emits keep, sos, eos, sym_idx, sf_done.
//   Top level: cp_sym_timer plus the output register.
// TESTING
//   Stimulus data = running input sample index n (real), ~n (imag).
//   1. sof at n=0, 30720 contiguous samples -> 28672 outputs; sym0 out n=160..2207; sym1 first out n=2352;
//      sym7 first out n=15520; sf_done once.
//   2. Same stream, valid_in randomly 50% low -> identical output sequence; valid_out only 1 clk after accepted samples.
//   3. Resync: sof again at n=5000 -> err_sync pulse; next sos_out with sym_idx=0 carries n=5160; no eos_out for the cut symbol.
//   4. rst low during symbol 3, then samples without sof -> all outputs 0; nothing forwarded until the next sof.
//   5. Two subframes, one sof -> sym_idx 13->0 wrap; 2nd sf sym0 first out n=30880; two sf_done pulses.
//   6. Macro on, WIN_OFFSET=8: sym0 outputs n=152..2199; sym1 first out n=2344; total still 28672 per subframe.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared constants, FSM state type and CP-length helpers for the RX cyclic-prefix removal block.
// CP_REMOVE_WIN_OFFSET_EN shortens the discarded CP by WIN_OFFSET and adds a TAIL discard.
package cp_pkg;

  localparam int IFFT_SIZE  = 2048;
  localparam int N_SYMB     = 14;
  localparam int NCP1       = 160;
  localparam int NCP2       = 144;
  localparam int WIN_OFFSET = 8;
  localparam int CNT_W      = 12;
  localparam int SYM_W      = 4;

  typedef enum logic [1:0] {IDLE, CP, BODY, TAIL} cp_state_t;

  function automatic logic [CNT_W-1:0] cp_len(input logic [SYM_W-1:0] sym);
    if (sym == '0 || sym == SYM_W'(N_SYMB / 2)) return CNT_W'(NCP1);
    else return CNT_W'(NCP2);
  endfunction

  // Samples actually dropped at the head of a symbol; the window may start inside the CP.
  function automatic logic [CNT_W-1:0] cp_discard(input logic [SYM_W-1:0] sym);
`ifdef CP_REMOVE_WIN_OFFSET_EN
    return cp_len(sym) - CNT_W'(WIN_OFFSET);
`else
    return cp_len(sym);
`endif
  endfunction

endpackage

// File: rtl/cp_sym_timer.sv
// Symbol timing FSM: tracks CP/body position per accepted sample and flags which samples to keep.
// Outputs are combinational for the current input sample; the top registers them.
module cp_sym_timer
  import cp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic             keep,
  output logic             sos,
  output logic             eos,
  output logic             sf_done,
  output logic             err_sync,
  output logic [SYM_W-1:0] sym_idx
);

  cp_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SYM_W-1:0] sym, sym_d;
  logic             sof_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      sym   <= '0;
    end else if (valid_in) begin
      state <= state_d;
      cnt   <= cnt_d;
      sym   <= sym_d;
    end
  end

  // A sof landing exactly on CP sample 0 of symbol 0 is consistent with current timing.
  assign sof_ok  = (state == CP) && (cnt == '0) && (sym == '0);
  assign sym_idx = sym;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    sym_d    = sym;
    keep     = 1'b0;
    sos      = 1'b0;
    eos      = 1'b0;
    sf_done  = 1'b0;
    err_sync = 1'b0;
    if (sof_in && !sof_ok) begin
      err_sync = (state != IDLE);
      state_d  = CP;
      cnt_d    = CNT_W'(1);
      sym_d    = '0;
    end else begin
      case (state)
        IDLE: ;
        CP: begin
          if (cnt == cp_discard(sym) - CNT_W'(1)) begin
            state_d = BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        BODY: begin
          keep = 1'b1;
          sos  = (cnt == '0);
          if (cnt == CNT_W'(IFFT_SIZE - 1)) begin
            eos   = 1'b1;
            cnt_d = '0;
`ifdef CP_REMOVE_WIN_OFFSET_EN
            state_d = TAIL;
`else
            state_d = CP;
`endif
            if (sym == SYM_W'(N_SYMB - 1)) begin
              sf_done = 1'b1;
              sym_d   = '0;
            end else begin
              sym_d = sym + SYM_W'(1);
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
`ifdef CP_REMOVE_WIN_OFFSET_EN
        TAIL: begin
          if (cnt == CNT_W'(WIN_OFFSET - 1)) begin
            state_d = CP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cp_removal.sv
// RX cyclic-prefix removal: forwards IFFT_SIZE body samples per symbol with framing markers.
// Optional FFT window advance into the CP via CP_REMOVE_WIN_OFFSET_EN.
module cp_removal
  import cp_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    sof_in,
  input  logic signed [WIDTH-1:0] data_in_r,
  input  logic signed [WIDTH-1:0] data_in_i,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] data_out_r,
  output logic signed [WIDTH-1:0] data_out_i,
  output logic [SYM_W-1:0]        sym_idx,
  output logic                    sos_out,
  output logic                    eos_out,
  output logic                    sf_done,
  output logic                    err_sync
);

  logic             keep_p0, sos_p0, eos_p0, sf_done_p0, err_p0;
  logic [SYM_W-1:0] sym_p0;

  cp_sym_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .sof_in   (sof_in),
    .keep     (keep_p0),
    .sos      (sos_p0),
    .eos      (eos_p0),
    .sf_done  (sf_done_p0),
    .err_sync (err_p0),
    .sym_idx  (sym_p0)
  );

  // p0 -> output register; data and sym_idx hold while nothing is forwarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      sos_out    <= 1'b0;
      eos_out    <= 1'b0;
      sf_done    <= 1'b0;
      err_sync   <= 1'b0;
      sym_idx    <= '0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      valid_out <= valid_in & keep_p0;
      sos_out   <= valid_in & sos_p0;
      eos_out   <= valid_in & eos_p0;
      sf_done   <= valid_in & sf_done_p0;
      err_sync  <= valid_in & err_p0;
      if (valid_in && keep_p0) begin
        sym_idx    <= sym_p0;
        data_out_r <= data_in_r;
        data_out_i <= data_in_i;
      end
    end
  end

endmodule

// File: tb/tb_cp_removal.sv
// Scoreboard bench for cp_removal: sample-index stimulus, expected body samples queued per subframe.
module tb_cp_removal;

  localparam int WIDTH = 26;
`ifdef CP_REMOVE_WIN_OFFSET_EN
  localparam int OFF = 8;
`else
  localparam int OFF = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in, sof_in;
  logic signed [WIDTH-1:0] data_in_r, data_in_i;
  logic                    valid_out, sos_out, eos_out, sf_done, err_sync;
  logic signed [WIDTH-1:0] data_out_r, data_out_i;
  logic [3:0]              sym_idx;

  cp_removal #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .sof_in(sof_in),
    .data_in_r(data_in_r), .data_in_i(data_in_i),
    .valid_out(valid_out), .data_out_r(data_out_r), .data_out_i(data_out_i),
    .sym_idx(sym_idx), .sos_out(sos_out), .eos_out(eos_out),
    .sf_done(sf_done), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  typedef struct {int n; int sym; bit sos; bit eos; bit sfd;} exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int out_cnt, sf_cnt, err_cnt, resync_sos;
  int sos_first[14];
  int sos0_q[$];
  logic signed [WIDTH-1:0] last_r, last_i;
  bit vin_prev;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected body samples of a subframe starting at n0, limited to indices below n_end.
  task automatic push_sf(input int n0, input int n_end);
    int start = n0;
    for (int s = 0; s < 14; s++) begin
      int cp = (s == 0 || s == 7) ? 160 : 144;
      for (int k = 0; k < 2048; k++) begin
        exp_t e;
        e.n = start + cp - OFF + k;
        if (e.n >= n_end) return;
        e.sym = s; e.sos = (k == 0); e.eos = (k == 2047); e.sfd = (k == 2047 && s == 13);
        exp_q.push_back(e);
      end
      start += cp + 2048;
    end
  endtask

  task automatic clear_stats();
    out_cnt = 0; sf_cnt = 0; err_cnt = 0; resync_sos = -1;
    for (int i = 0; i < 14; i++) sos_first[i] = -1;
    sos0_q.delete();
  endtask

  task automatic send(input int n, input bit sof, input bit gaps);
    if (gaps) begin
      while ($urandom_range(1) == 0) begin
        valid_in = 1'b0; sof_in = 1'($urandom_range(1)); data_in_r = WIDTH'($urandom);
        @(posedge clk); #1;
      end
    end
    valid_in = 1'b1; sof_in = sof;
    data_in_r = WIDTH'(n); data_in_i = ~WIDTH'(n);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    valid_in = 1'b0; sof_in = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {valid_out, sos_out, eos_out, sf_done, err_sync, sym_idx, data_out_r, data_out_i}, 0);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_r = '0; last_i = '0; vin_prev = 1'b0;
      end else begin
        if (err_sync) err_cnt++;
        if (valid_out) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out actual n=%0d sym=%0d required no output", data_out_r, sym_idx);
          end else begin
            exp_t e = exp_q.pop_front();
            logic signed [WIDTH-1:0] er = WIDTH'(e.n);
            logic signed [WIDTH-1:0] ei = ~er;
            checks++;
            if (!vin_prev || data_out_r !== er || data_out_i !== ei || sym_idx !== 4'(e.sym) ||
                sos_out !== e.sos || eos_out !== e.eos || sf_done !== e.sfd) begin
              failures++;
              $display("FAIL out_word actual vin=%0b n=%0d i=%0d sym=%0d sos=%0b eos=%0b sfd=%0b required vin=1 n=%0d i=%0d sym=%0d sos=%0b eos=%0b sfd=%0b",
                       vin_prev, data_out_r, data_out_i, sym_idx, sos_out, eos_out, sf_done,
                       er, ei, e.sym, e.sos, e.eos, e.sfd);
            end
          end
          if (sos_out) begin
            if (sos_first[sym_idx] < 0) sos_first[sym_idx] = int'(data_out_r);
            if (sym_idx == 0) sos0_q.push_back(int'(data_out_r));
            if (sym_idx == 0 && err_cnt > 0 && resync_sos < 0) resync_sos = int'(data_out_r);
          end
          if (sf_done) sf_cnt++;
          last_r = data_out_r; last_i = data_out_i;
        end else begin
          chk("idle_quiet", {sos_out, eos_out, sf_done, data_out_r, data_out_i}, {3'b000, last_r, last_i});
        end
        vin_prev = valid_in;
      end
    end
  endtask

  initial begin
    rst = 1'b0; valid_in = 1'b0; sof_in = 1'b0; data_in_r = '0; data_in_i = '0;
    fork
      monitor();
      begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk); #1;
    chk_all_zero("reset_outputs");
    rst = 1'b1;

    // Two contiguous subframes from one sof, 50% valid gaps around the subframe boundary
    clear_stats();
    push_sf(0, 30720); push_sf(30720, 61440);
    for (int n = 0; n < 61440; n++) send(n, n == 0, n >= 29500 && n < 32500);
    idle(3);
    chk("A_out_cnt", out_cnt, 57344);
    chk("A_sf_done_cnt", sf_cnt, 2);
    chk("A_sym0_first", sos_first[0], 160 - OFF);
    chk("A_sym1_first", sos_first[1], 2352 - OFF);
    chk("A_sym7_first", sos_first[7], 15520 - OFF);
    chk("A_sym0_sos_cnt", sos0_q.size(), 2);
    if (sos0_q.size() >= 2) chk("A_sf2_sym0_first", sos0_q[1], 30880 - OFF);
    chk("A_err_cnt", err_cnt, 0);
    chk("A_queue_empty", exp_q.size(), 0);

    // Resync: second sof at n=5000 truncates symbol 2 without an eos
    rst = 1'b0; idle(2); rst = 1'b1; idle(1);
    clear_stats();
    push_sf(0, 5000); push_sf(5000, 5400);
    for (int n = 0; n < 5400; n++) send(n, n == 0 || n == 5000, 1'b0);
    idle(3);
    chk("B_err_cnt", err_cnt, 1);
    chk("B_resync_sym0_first", resync_sos, 5160 - OFF);
    chk("B_queue_empty", exp_q.size(), 0);

    // Reset during symbol 3, then samples without sof, then a fresh sof
    clear_stats();
    push_sf(0, 6900);
    for (int n = 0; n < 6900; n++) send(n, n == 0, 1'b0);
    idle(1);
    valid_in = 1'b1; data_in_r = WIDTH'(6900); data_in_i = ~WIDTH'(6900);
    #2 rst = 1'b0;
    #1 chk_all_zero("C_async_reset");
    repeat (2) @(posedge clk); #1;
    chk_all_zero("C_reset_held");
    rst = 1'b1;
    chk("C_queue_before_reset", exp_q.size(), 0);
    clear_stats();
    for (int n = 10000; n < 11000; n++) send(n, 1'b0, 1'b0);
    idle(2);
    chk("C_nosof_no_output", out_cnt, 0);
    chk_all_zero("C_nosof_outputs");
    push_sf(20000, 20400);
    for (int n = 20000; n < 20400; n++) send(n, n == 20000, 1'b0);
    idle(3);
    chk("C_rearm_sym0_first", sos_first[0], 20160 - OFF);
    chk("C_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
